control: RTL and testbench
==========================

// Module: control
// PURPOSE
//  Main instruction decoder of the single-issue MIPS-like core. Takes the 32-bit
//  instruction word and produces one registered 32-bit control bundle for the
//  datapath: register addresses, write enables, mux selects, ALU and multiplier controls.
//  Sits between instruction fetch and the register file / ALU / data memory.
// PARAMETERS
//  none (opcodes and funct codes are fixed localparams)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  instruction  in   32  instruction word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] / imm[15:0]
//  out          out  32  control bundle (field map below)
// BEHAVIOUR
//  Interface: one clock (clk); reset rst_n is asynchronous, active-low.
//  out map: [31:24] reserved = 0 | [23] extend_ctrl (1 = sign-extend imm) | [22] mul_ctrl (1 = multiplier result)
//   | [21:17] rs | [16:12] rt | [11:7] rd | [6] wr_reg_file | [5] wr (data mem write)
//   | [4] mux_wb (1 = mem data, 0 = ALU/mul) | [3] mux_reg (1 = dest rd, 0 = dest rt)
//   | [2] mux_alu (1 = imm, 0 = rt) | [1:0] alu_ctrl (00 add, 01 sub, 10 and, 11 or)
//  Timing: pure combinational decode, registered into out on rising clk; latency 1 cycle.
//   No handshake; new instruction accepted every cycle.
//  Reset: rst_n low -> out = 32'h0 immediately (NOP: no writes); held until first clk edge after release.
//  Opcode 6'b001111 (R group): rs=ins[25:21], rt=ins[20:16], rd=ins[15:11], wr_reg_file=1,
//   wr=0, mux_wb=0, mux_reg=1, mux_alu=0, extend_ctrl=0. Funct:
//    100000 ADD alu=00 mul=0 | 100010 SUB alu=01 mul=0 | 100100 AND alu=10 mul=0
//    100101 OR alu=11 mul=0 | 110010 MUL alu=00 mul=1. shamt ignored.
//  Opcode 6'b010000 LW: rs, rt passed; rd=0; extend=1, mul=0, wr_reg_file=1, wr=0,
//   mux_wb=1, mux_reg=0, mux_alu=1, alu=00 (address = rs + sext(imm)).
//  Opcode 6'b010001 SW: rs, rt passed; rd=0; extend=1, mul=0, wr_reg_file=0, wr=1,
//   mux_wb=0, mux_reg=0, mux_alu=1, alu=00.
//  Any other opcode, or R group with unlisted funct: out registered as 32'h0 (NOP).
//  Bits [31:24] always 0. Reset mid-stream discards the pending decode; no other state exists.
//  X/Z on instruction need not be handled beyond simulation (treated as illegal -> NOP).
// TESTING
//  Reset: rst_n=0 with any instruction -> out=32'h00000000 asynchronously; stays 0 until next edge after release.
//  LW 32'h40010000 -> one clk later out=32'h00801054; LW 32'h40020001 -> 32'h00802054.
//  ADD 32'h3C22_1AA0 (rs1 rt2 rd3 funct 100000) -> 32'h000221C8; SUB (funct 100010) -> 32'h000221C9.
//  MUL (funct 110010) -> 32'h004221C8; AND (100100) -> 32'h000221CA; OR (100101) -> 32'h000221CB.
//  SW 32'h44030003 (rs0 rt3) -> 32'h00803024.
//  Illegal: opcode 6'b000000 or R group funct 6'b000001 -> 32'h00000000; back-to-back
//   instructions each visible exactly one cycle later.

Source files
------------

// File: rtl/control.sv
// Main instruction decoder: turns a 32-bit instruction word into one registered
// control bundle for the datapath. Anything it does not recognise decodes to a NOP.
module control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] out
);

  localparam logic [5:0] OP_RGRP  = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b010000;
  localparam logic [5:0] OP_SW    = 6'b010001;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_MUL   = 6'b110010;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        legal;
  logic        extend_ctrl;
  logic        mul_ctrl;
  logic        wr_reg_file;
  logic        wr;
  logic        mux_wb;
  logic        mux_reg;
  logic        mux_alu;
  logic [1:0]  alu_ctrl;
  logic [4:0]  rd_sel;

  logic [31:0] out_d;
  logic [31:0] out_q;

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign funct = instruction[5:0];

  always_comb begin
    legal       = 1'b0;
    extend_ctrl = 1'b0;
    mul_ctrl    = 1'b0;
    wr_reg_file = 1'b0;
    wr          = 1'b0;
    mux_wb      = 1'b0;
    mux_reg     = 1'b0;
    mux_alu     = 1'b0;
    alu_ctrl    = ALU_ADD;
    rd_sel      = 5'd0;

    case (op)
      OP_RGRP: begin
        wr_reg_file = 1'b1;
        mux_reg     = 1'b1;
        rd_sel      = rd;
        legal       = 1'b1;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_MUL:  mul_ctrl = 1'b1;
          default: legal    = 1'b0;
        endcase
      end
      OP_LW: begin
        legal       = 1'b1;
        extend_ctrl = 1'b1;
        wr_reg_file = 1'b1;
        mux_wb      = 1'b1;
        mux_alu     = 1'b1;
      end
      OP_SW: begin
        legal       = 1'b1;
        extend_ctrl = 1'b1;
        wr          = 1'b1;
        mux_alu     = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings (including X/Z in simulation) collapse to an all-zero NOP.
    out_d = 32'h0;
    if (legal) begin
      out_d = {8'h00, extend_ctrl, mul_ctrl, rs, rt, rd_sel,
               wr_reg_file, wr, mux_wb, mux_reg, mux_alu, alu_ctrl};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 32'h0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_control.sv
// Directed bench for the control decoder: hand-computed bundles for each opcode,
// illegal encodings, back-to-back latency and asynchronous reset.
module tb_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] out_w;

  int n_cmp;
  int n_bad;

  control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .out         (out_w)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply an instruction and check the bundle #1 after the next rising edge.
  task automatic apply_and_check(input string name, input logic [31:0] ins,
                                 input logic [31:0] exp);
    instruction = ins;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_w !== exp) begin
      n_bad++;
      $display("FAIL %s: ins=%h out=%h expected=%h", name, ins, out_w, exp);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    instruction = 32'h40010000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_w !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_hold: out=%h expected=%h", out_w, 32'h0);
    end
    // Release between edges: output must stay zero until the next edge.
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (out_w !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_release: out=%h expected=%h", out_w, 32'h0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_w !== 32'h00801054) begin
      n_bad++;
      $display("FAIL reset_first_edge: out=%h expected=%h", out_w, 32'h00801054);
    end
  endtask

  task automatic test_lw();
    apply_and_check("lw_rt1", 32'h40010000, 32'h00801054);
    apply_and_check("lw_rt2", 32'h40020001, 32'h00802054);
    // rs=31 rt=31, imm with rd-looking bits set: rd must stay 0
    apply_and_check("lw_max", 32'h43FFFFFF, 32'h0083F054 | 32'h003E0000);
  endtask

  task automatic test_r_group();
    apply_and_check("add", 32'h3C221AA0, 32'h000221C8);
    apply_and_check("sub", 32'h3C221AA2, 32'h000221C9);
    apply_and_check("mul", 32'h3C221AB2, 32'h004221C8);
    apply_and_check("and", 32'h3C221AA4, 32'h000221CA);
    apply_and_check("or",  32'h3C221AA5, 32'h000221CB);
    // rs=31 rt=31 rd=31 shamt=31 ADD
    apply_and_check("add_max", 32'h3FFFFFE0, 32'h003FFFC8);
  endtask

  task automatic test_sw();
    apply_and_check("sw", 32'h44030003, 32'h00803024);
    apply_and_check("sw_rs5", 32'h44A4F800, 32'h008A4024);
  endtask

  task automatic test_illegal();
    apply_and_check("lw_before_illegal", 32'h40010000, 32'h00801054);
    apply_and_check("op_zero", 32'h00221AA0, 32'h00000000);
    apply_and_check("bad_funct", 32'h3C221AA1, 32'h00000000);
    apply_and_check("op_3f", 32'hFC221AA0, 32'h00000000);
    apply_and_check("op_x", 32'hxxxxxxxx, 32'h00000000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins_v [6];
    logic [31:0] exp_v [6];
    logic [31:0] prev;
    ins_v = '{32'h40010000, 32'h3C221AA2, 32'h44030003, 32'h3C221AB2, 32'h00000000, 32'h40020001};
    exp_v = '{32'h00801054, 32'h000221C9, 32'h00803024, 32'h004221C8, 32'h00000000, 32'h00802054};
    instruction = 32'h0;
    @(posedge clk);
    #1;
    prev = 32'h0;
    for (int i = 0; i < 6; i++) begin
      instruction = ins_v[i];
      #2;
      // Before the edge the previous bundle must still be showing.
      n_cmp++;
      if (out_w !== prev) begin
        n_bad++;
        $display("FAIL b2b_hold[%0d]: out=%h expected=%h", i, out_w, prev);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_w !== exp_v[i]) begin
        n_bad++;
        $display("FAIL b2b[%0d]: out=%h expected=%h", i, out_w, exp_v[i]);
      end
      prev = exp_v[i];
    end
  endtask

  task automatic test_async_reset_midstream();
    apply_and_check("pre_reset", 32'h3C221AA5, 32'h000221CB);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_w !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: out=%h expected=%h", out_w, 32'h0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply_and_check("post_reset", 32'h44030003, 32'h00803024);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    instruction = 32'h0;
    test_reset();
    test_lw();
    test_r_group();
    test_sw();
    test_illegal();
    test_back_to_back();
    test_async_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
